// File: rtl/snake_pkg.sv
// snake_pkg: shared constants and helpers for the snake input controller.
//   Direction encoding (dir_t): UP=0, DOWN=1, LEFT=2, RIGHT=3.
//   Screen encoding (screen_e): MENU=0, PLAY=1, PAUSED=2, OVER=3.
//   Button indices into btn_raw / btn_pressed: BTN_UP..BTN_PAUSE.
//   opposite_dir(): UP<->DOWN and LEFT<->RIGHT differ only in bit 0.
package snake_pkg;

   typedef logic [1:0] dir_t;

   localparam dir_t UP    = 2'd0;
   localparam dir_t DOWN  = 2'd1;
   localparam dir_t LEFT  = 2'd2;
   localparam dir_t RIGHT = 2'd3;

   typedef enum logic [1:0] {
      MENU   = 2'd0,
      PLAY   = 2'd1,
      PAUSED = 2'd2,
      OVER   = 2'd3
   } screen_e;

   localparam int NUM_BTN   = 5;
   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_PAUSE = 4;

   function automatic dir_t opposite_dir(input dir_t d);
      return d ^ 2'b01;
   endfunction

endpackage

// File: rtl/snake_input_ctrl_if.sv
// snake_input_ctrl_if: bundle between the board/game side and the input controller.
//   btn_raw[4:0]     raw buttons (up, down, left, right, pause/start)
//   move_tick        one-cycle strobe: snake advances, pop next turn
//   game_over        level from game logic
//   btn_pressed[4:0] one-cycle press pulses
//   move_dir[1:0]    current direction
//   screen[1:0]      screen state
//   is_paused        screen == PAUSED
//   queue_full       turn queue full
// Modports: master = game/board side (drives inputs), slave = controller.
interface snake_input_ctrl_if;
   import snake_pkg::*;

   logic [NUM_BTN-1:0] btn_raw;
   logic               move_tick;
   logic               game_over;
   logic [NUM_BTN-1:0] btn_pressed;
   dir_t               move_dir;
   logic [1:0]         screen;
   logic               is_paused;
   logic               queue_full;

   modport master (
      output btn_raw, move_tick, game_over,
      input  btn_pressed, move_dir, screen, is_paused, queue_full
   );

   modport slave (
      input  btn_raw, move_tick, game_over,
      output btn_pressed, move_dir, screen, is_paused, queue_full
   );

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: one button channel -- 2-flop synchroniser, stability counter,
// debounced level and registered one-cycle press pulse.
//   clk, rst_n  clock, asynchronous active-low reset
//   raw         asynchronous button input
//   level       debounced level
//   pressed     one-cycle pulse on a rising debounced level
// The pulse path is armed only once the synchroniser holds real data and the
// button has been seen released, so a button held through reset never pulses.
module btn_debounce #(
   parameter int DB_CYCLES = 250000,
   parameter int DB_W      = 18
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic pressed
);

   localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);
   localparam logic [DB_W-1:0] CNT_ONE  = {{(DB_W-1){1'b0}}, 1'b1};

   logic            sync1_r;
   logic            sync2_r;
   logic [1:0]      fill_r;
   logic            armed_r;
   logic [DB_W-1:0] cnt_r;
   logic            level_r;
   logic            level_d_r;
   logic            pressed_r;

   // Two-flop synchroniser plus a fill marker showing when sync2_r is valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         fill_r  <= 2'b00;
      end else begin
         sync1_r <= raw;
         sync2_r <= sync1_r;
         fill_r  <= {fill_r[0], 1'b1};
      end
   end

   // Stability counter: the level flips after DB_CYCLES differing cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r   <= '0;
         level_r <= 1'b0;
      end else if (sync2_r != level_r) begin
         if (cnt_r == CNT_LAST) begin
            level_r <= sync2_r;
            cnt_r   <= '0;
         end else begin
            cnt_r   <= cnt_r + CNT_ONE;
         end
      end else begin
         cnt_r <= '0;
      end
   end

   // Arm once a genuinely released button has been observed after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_r <= 1'b0;
      end else if (fill_r[1] && !sync2_r && !level_r) begin
         armed_r <= 1'b1;
      end else begin
         armed_r <= armed_r;
      end
   end

   // Registered rising-edge detector on the debounced level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_d_r <= 1'b0;
         pressed_r <= 1'b0;
      end else begin
         level_d_r <= level_r;
         pressed_r <= level_r & ~level_d_r & armed_r;
      end
   end

   assign level   = level_r;
   assign pressed = pressed_r;

endmodule

// File: rtl/snake_input_ctrl.sv
// snake_input_ctrl: button debounce, press pulses, turn queue and screen FSM.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         snake_input_ctrl_if.slave (btn_raw, move_tick, game_over in;
//               btn_pressed, move_dir, screen, is_paused, queue_full out)
// Optional feature macro SNAKE_LONGPRESS_EN: holding pause for LONG_CYCLES
// while PAUSED returns to MENU and flushes the queue.
module snake_input_ctrl
   import snake_pkg::*;
#(
   parameter int DB_CYCLES   = 250000,
   parameter int DB_W        = 18,
   parameter int QUEUE_DEPTH = 2,
   parameter int LONG_CYCLES = 50000000
) (
   input logic               clk,
   input logic               rst_n,
   snake_input_ctrl_if.slave bus
);

   localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] Q_FULL  = CW'(QUEUE_DEPTH);

   logic [NUM_BTN-1:0] level_s;
   logic [NUM_BTN-1:0] pressed_s;

   screen_e       screen_r;
   screen_e       screen_next_s;
   logic          is_paused_r;
   logic          queue_full_r;
   dir_t          move_dir_r;

   dir_t          q_mem_r [QUEUE_DEPTH];
   logic [AW-1:0] head_r;
   logic [AW-1:0] tail_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_next_s;

   logic          pause_s;
   logic          in_play_s;
   logic          menu_to_play_s;
   logic          flush_s;
   logic          long_hit_s;
   logic          cand_valid_s;
   dir_t          cand_s;
   dir_t          ref_s;
   logic          push_s;
   logic          pop_s;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(
         .DB_CYCLES (DB_CYCLES),
         .DB_W      (DB_W)
      ) u_db (
         .clk     (clk),
         .rst_n   (rst_n),
         .raw     (bus.btn_raw[i]),
         .level   (level_s[i]),
         .pressed (pressed_s[i])
      );
   end

   assign pause_s = pressed_s[BTN_PAUSE];

`ifdef SNAKE_LONGPRESS_EN
   localparam int LW = $clog2(LONG_CYCLES + 1);
   localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYCLES - 1);
   localparam logic [LW-1:0] HOLD_ONE  = {{(LW-1){1'b0}}, 1'b1};
   logic [LW-1:0] hold_cnt_r;
   logic          unused_levels_s;

   // Counts consecutive paused cycles with the debounced pause level high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_r <= '0;
      end else if ((screen_r == PAUSED) && level_s[BTN_PAUSE]) begin
         if (hold_cnt_r != HOLD_LAST) begin
            hold_cnt_r <= hold_cnt_r + HOLD_ONE;
         end else begin
            hold_cnt_r <= hold_cnt_r;
         end
      end else begin
         hold_cnt_r <= '0;
      end
   end

   assign long_hit_s = (screen_r == PAUSED) && level_s[BTN_PAUSE] &&
                       (hold_cnt_r == HOLD_LAST);
   assign unused_levels_s = ^level_s[BTN_RIGHT:BTN_UP];
`else
   localparam int unused_long_cycles = LONG_CYCLES;
   logic          unused_levels_s;

   assign long_hit_s      = 1'b0;
   assign unused_levels_s = ^level_s;
`endif

   // Screen state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         screen_r <= MENU;
      end else begin
         screen_r <= screen_next_s;
      end
   end

   // Screen next-state logic; game_over beats a same-cycle pause pulse.
   always_comb begin
      screen_next_s = screen_r;
      case (screen_r)
         MENU: begin
            if (pause_s) screen_next_s = PLAY;
            else         screen_next_s = MENU;
         end
         PLAY: begin
            if (bus.game_over) screen_next_s = OVER;
            else if (pause_s)  screen_next_s = PAUSED;
            else               screen_next_s = PLAY;
         end
         PAUSED: begin
            if (long_hit_s)   screen_next_s = MENU;
            else if (pause_s) screen_next_s = PLAY;
            else              screen_next_s = PAUSED;
         end
         OVER: begin
            if (pause_s) screen_next_s = MENU;
            else         screen_next_s = OVER;
         end
         default: screen_next_s = MENU;
      endcase
   end

   // Screen-dependent controls for the queue and direction register.
   always_comb begin
      in_play_s      = (screen_r == PLAY);
      menu_to_play_s = (screen_r == MENU) && pause_s;
      flush_s        = menu_to_play_s || long_hit_s;
   end

   // Candidate direction: at most one, priority up > down > left > right.
   always_comb begin
      cand_valid_s = 1'b0;
      cand_s       = RIGHT;
      if (pressed_s[BTN_UP]) begin
         cand_valid_s = 1'b1;
         cand_s       = UP;
      end else if (pressed_s[BTN_DOWN]) begin
         cand_valid_s = 1'b1;
         cand_s       = DOWN;
      end else if (pressed_s[BTN_LEFT]) begin
         cand_valid_s = 1'b1;
         cand_s       = LEFT;
      end else if (pressed_s[BTN_RIGHT]) begin
         cand_valid_s = 1'b1;
         cand_s       = RIGHT;
      end else begin
         cand_valid_s = 1'b0;
         cand_s       = RIGHT;
      end
   end

   // Reference is the newest queued turn, else the current direction.
   always_comb begin
      ref_s = move_dir_r;
      if (count_r != '0) begin
         ref_s = q_mem_r[tail_r - PTR_ONE];
      end else begin
         ref_s = move_dir_r;
      end
   end

   // Push/pop decisions and the resulting entry count.
   always_comb begin
      push_s = in_play_s && cand_valid_s && (count_r != Q_FULL) &&
               (cand_s != ref_s) && (cand_s != opposite_dir(ref_s));
      pop_s  = in_play_s && bus.move_tick && (count_r != '0);
      count_next_s = count_r;
      if (flush_s) begin
         count_next_s = '0;
      end else if (push_s && !pop_s) begin
         count_next_s = count_r + CNT_ONE;
      end else if (pop_s && !push_s) begin
         count_next_s = count_r - CNT_ONE;
      end else begin
         count_next_s = count_r;
      end
   end

   // Turn queue storage and pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            q_mem_r[i] <= RIGHT;
         end
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else if (flush_s) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else begin
         if (push_s) begin
            q_mem_r[tail_r] <= cand_s;
            tail_r          <= tail_r + PTR_ONE;
         end else begin
            tail_r <= tail_r;
         end
         if (pop_s) begin
            head_r <= head_r + PTR_ONE;
         end else begin
            head_r <= head_r;
         end
         count_r <= count_next_s;
      end
   end

   // Current direction: forced RIGHT when a game starts, else takes the head on pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         move_dir_r <= RIGHT;
      end else if (menu_to_play_s) begin
         move_dir_r <= RIGHT;
      end else if (pop_s) begin
         move_dir_r <= q_mem_r[head_r];
      end else begin
         move_dir_r <= move_dir_r;
      end
   end

   // Status flags registered from next-state values so they track screen/count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_paused_r  <= 1'b0;
         queue_full_r <= 1'b0;
      end else begin
         is_paused_r  <= (screen_next_s == PAUSED);
         queue_full_r <= (count_next_s == Q_FULL);
      end
   end

   assign bus.btn_pressed = pressed_s;
   assign bus.move_dir    = move_dir_r;
   assign bus.screen      = screen_r;
   assign bus.is_paused   = is_paused_r;
   assign bus.queue_full  = queue_full_r;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// tb_snake_input_ctrl: directed bench for snake_input_ctrl with DB_CYCLES=4,
// QUEUE_DEPTH=2. Expected values are hand-derived constants.
module tb_snake_input_ctrl;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   snake_input_ctrl_if bus ();

   snake_input_ctrl #(
      .DB_CYCLES   (4),
      .DB_W        (3),
      .QUEUE_DEPTH (2),
      .LONG_CYCLES (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Hold mask for 10 clocks (pulse lands at clock 7), then release and settle.
   task automatic press(input logic [4:0] mask);
      bus.btn_raw = mask;
      cyc(10);
      bus.btn_raw = 5'b00000;
      cyc(8);
   endtask

   task automatic tick();
      bus.move_tick = 1'b1;
      cyc(1);
      bus.move_tick = 1'b0;
      cyc(1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pressed"}, 32'(bus.btn_pressed), 32'd0);
      check({tag, "_dir"},     32'(bus.move_dir),    32'd3);
      check({tag, "_screen"},  32'(bus.screen),      32'd0);
      check({tag, "_paused"},  32'(bus.is_paused),   32'd0);
      check({tag, "_full"},    32'(bus.queue_full),  32'd0);
   endtask

   initial begin
      int pcnt;
      int pat;
      n_vec         = 0;
      n_err         = 0;
      rst_n         = 1'b0;
      bus.btn_raw   = 5'b00000;
      bus.move_tick = 1'b0;
      bus.game_over = 1'b0;
      #12;
      check_reset_outputs("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(5);

      // Two-cycle glitch must not produce a pulse.
      pcnt = 0;
      bus.btn_raw = 5'b00001;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (k == 2) bus.btn_raw = 5'b00000;
         if (bus.btn_pressed != 5'b00000) pcnt++;
      end
      check("glitch_pulses", 32'(pcnt), 32'd0);

      // Clean press: one pulse, 7 clocks after the raw edge; release silent.
      pcnt = 0;
      pat  = 0;
      bus.btn_raw = 5'b00001;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (bus.btn_pressed[0]) begin
            pcnt++;
            pat = k;
         end
         if (k == 10) bus.btn_raw = 5'b00000;
      end
      check("press_pulses", 32'(pcnt), 32'd1);
      check("press_latency", 32'(pat), 32'd7);
      check("menu_ignores_dir", 32'(bus.screen), 32'd0);

      // Screen FSM walk.
      press(5'b10000);
      check("fsm_play", 32'(bus.screen), 32'd1);
      check("fsm_play_dir", 32'(bus.move_dir), 32'd3);
      press(5'b10000);
      check("fsm_paused", 32'(bus.screen), 32'd2);
      check("fsm_is_paused", 32'(bus.is_paused), 32'd1);
      press(5'b10000);
      check("fsm_resume", 32'(bus.screen), 32'd1);
      check("fsm_resume_flag", 32'(bus.is_paused), 32'd0);
      bus.game_over = 1'b1;
      cyc(1);
      check("fsm_over", 32'(bus.screen), 32'd3);
      bus.game_over = 1'b0;
      cyc(1);
      press(5'b10000);
      check("fsm_menu", 32'(bus.screen), 32'd0);

      // Reversal and duplicate are dropped.
      press(5'b10000);
      check("rev_play", 32'(bus.screen), 32'd1);
      press(5'b00100);
      press(5'b01000);
      check("rev_full", 32'(bus.queue_full), 32'd0);
      tick();
      check("rev_dir", 32'(bus.move_dir), 32'd3);

      // Queue fill, overflow drop, ordered pops, empty tick.
      press(5'b00001);
      check("q_one_full", 32'(bus.queue_full), 32'd0);
      press(5'b00100);
      check("q_full", 32'(bus.queue_full), 32'd1);
      press(5'b00010);
      check("q_still_full", 32'(bus.queue_full), 32'd1);
      tick();
      check("q_pop1", 32'(bus.move_dir), 32'd0);
      check("q_pop1_full", 32'(bus.queue_full), 32'd0);
      tick();
      check("q_pop2", 32'(bus.move_dir), 32'd2);
      tick();
      check("q_empty_tick", 32'(bus.move_dir), 32'd2);

      // Simultaneous up+down queues only UP.
      press(5'b00011);
      tick();
      check("sim_up", 32'(bus.move_dir), 32'd0);
      tick();
      check("sim_no_down", 32'(bus.move_dir), 32'd0);

      // Push coinciding with a pop keeps the count.
      press(5'b00100);
      bus.btn_raw = 5'b00010;
      for (int k = 1; k <= 10; k++) begin
         bus.move_tick = (k == 8);
         @(posedge clk);
         #1;
      end
      bus.move_tick = 1'b0;
      bus.btn_raw   = 5'b00000;
      cyc(8);
      check("pp_dir", 32'(bus.move_dir), 32'd2);
      check("pp_full", 32'(bus.queue_full), 32'd0);
      press(5'b01000);
      check("pp_full2", 32'(bus.queue_full), 32'd1);
      tick();
      check("pp_pop1", 32'(bus.move_dir), 32'd1);
      tick();
      check("pp_pop2", 32'(bus.move_dir), 32'd3);

      // Reset in PAUSED with two entries queued and buttons held.
      press(5'b00001);
      press(5'b00100);
      press(5'b10000);
      check("mid_paused", 32'(bus.is_paused), 32'd1);
      check("mid_full", 32'(bus.queue_full), 32'd1);
      bus.btn_raw = 5'b10001;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      cyc(3);
      rst_n = 1'b1;
      pcnt = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (bus.btn_pressed != 5'b00000) pcnt++;
      end
      check("post_rst_pulses", 32'(pcnt), 32'd0);
      check("post_rst_screen", 32'(bus.screen), 32'd0);
      bus.btn_raw = 5'b00000;
      cyc(10);
      press(5'b10000);
      check("post_rst_play", 32'(bus.screen), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
